// File: rtl/puf_pipeline_sequencer.sv
// Per-request sequencer for the PUF response path: launches the PUF, then optional ECC and SHA-256,
// with a per-stage watchdog and exactly one result-valid (or error) per accepted request.
module puf_pipeline_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned CNT_W          = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] mode,
  input  logic [7:0] challenge_in,
  output logic       puf_start,
  output logic [7:0] puf_challenge,
  input  logic       puf_done,
  output logic       ecc_start,
  input  logic       ecc_ready,
  output logic       sha_init,
  input  logic       sha_ready,
  input  logic       sha_digest_valid,
  output logic       mem_we,
  output logic [1:0] resp_sel,
  output logic       resp_dv,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_stage,
  output logic       dropped
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] MODE_RAW    = 2'b00;
  localparam logic [1:0] MODE_CORR   = 2'b01;
  localparam logic [1:0] MODE_HASH   = 2'b10;

  localparam logic [1:0] STG_PUF      = 2'd0;
  localparam logic [1:0] STG_ECC      = 2'd1;
  localparam logic [1:0] STG_SHA_WAIT = 2'd2;
  localparam logic [1:0] STG_SHA_RUN  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUF_RUN,
    S_ECC_RUN,
    S_SHA_WAIT,
    S_SHA_RUN,
    S_ENROLL,
    S_DELIVER,
    S_ERROR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wdog;
  logic             wd_expired;

  assign wd_expired = (wdog == WD_LAST);

  // Pulses default low each cycle; the watchdog restarts from zero on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      wdog          <= '0;
      puf_start     <= 1'b0;
      puf_challenge <= '0;
      ecc_start     <= 1'b0;
      sha_init      <= 1'b0;
      mem_we        <= 1'b0;
      resp_sel      <= '0;
      resp_dv       <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      err_stage     <= '0;
      dropped       <= 1'b0;
    end else begin
      puf_start <= 1'b0;
      ecc_start <= 1'b0;
      sha_init  <= 1'b0;
      mem_we    <= 1'b0;
      resp_dv   <= 1'b0;
      dropped   <= req && (state != S_IDLE);
      wdog      <= '0;

      case (state)
        S_IDLE: begin
          if (req) begin
            resp_sel      <= mode;
            puf_challenge <= challenge_in;
            err           <= 1'b0;
            err_stage     <= '0;
            busy          <= 1'b1;
            puf_start     <= 1'b1;
            state         <= S_PUF_RUN;
          end
        end

        S_PUF_RUN: begin
          if (puf_done) begin
            case (resp_sel)
              MODE_RAW: begin
                resp_dv <= 1'b1;
                state   <= S_DELIVER;
              end
              MODE_CORR, MODE_HASH: begin
                ecc_start <= 1'b1;
                state     <= S_ECC_RUN;
              end
              default: begin
                mem_we <= 1'b1;
                state  <= S_ENROLL;
              end
            endcase
          end else if (wd_expired) begin
            err       <= 1'b1;
            err_stage <= STG_PUF;
            state     <= S_ERROR;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end

        S_ECC_RUN: begin
          if (ecc_ready) begin
            if (resp_sel == MODE_HASH) begin
              state <= S_SHA_WAIT;
            end else begin
              resp_dv <= 1'b1;
              state   <= S_DELIVER;
            end
          end else if (wd_expired) begin
            err       <= 1'b1;
            err_stage <= STG_ECC;
            state     <= S_ERROR;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end

        S_SHA_WAIT: begin
          if (sha_ready) begin
            sha_init <= 1'b1;
            state    <= S_SHA_RUN;
          end else if (wd_expired) begin
            err       <= 1'b1;
            err_stage <= STG_SHA_WAIT;
            state     <= S_ERROR;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end

        S_SHA_RUN: begin
          // sha_init marks the init cycle, where a digest-valid cannot belong to this request
          if (!sha_init && sha_digest_valid) begin
            resp_dv <= 1'b1;
            state   <= S_DELIVER;
          end else if (wd_expired) begin
            err       <= 1'b1;
            err_stage <= STG_SHA_RUN;
            state     <= S_ERROR;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end

        S_ENROLL: begin
          resp_dv <= 1'b1;
          state   <= S_DELIVER;
        end

        S_DELIVER: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        S_ERROR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_pipeline_sequencer.sv
// Self-checking bench for puf_pipeline_sequencer: each transaction's expected pulse timeline is
// derived from the stage delays chosen by the bench and compared cycle by cycle.
module tb_puf_pipeline_sequencer;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic [1:0] mode;
  logic [7:0] challenge_in;
  logic       puf_start;
  logic [7:0] puf_challenge;
  logic       puf_done;
  logic       ecc_start;
  logic       ecc_ready;
  logic       sha_init;
  logic       sha_ready;
  logic       sha_digest_valid;
  logic       mem_we;
  logic [1:0] resp_sel;
  logic       resp_dv;
  logic       busy;
  logic       err;
  logic [1:0] err_stage;
  logic       dropped;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  puf_pipeline_sequencer #(
    .TIMEOUT_CYCLES(T),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .mode(mode),
    .challenge_in(challenge_in),
    .puf_start(puf_start),
    .puf_challenge(puf_challenge),
    .puf_done(puf_done),
    .ecc_start(ecc_start),
    .ecc_ready(ecc_ready),
    .sha_init(sha_init),
    .sha_ready(sha_ready),
    .sha_digest_valid(sha_digest_valid),
    .mem_we(mem_we),
    .resp_sel(resp_sel),
    .resp_dv(resp_dv),
    .busy(busy),
    .err(err),
    .err_stage(err_stage),
    .dropped(dropped)
  );

  // One request. Relative cycle 0 carries req; dp/de/dw/dv are stage delays measured from each
  // stage's first cycle. A stage completes only if its delay is at most T-1 cycles.
  task automatic run_txn(input logic [1:0] m, input logic [7:0] ch, input int dp, input int de,
                         input int dw, input int dv, input bit rdy_early, input int drop_a,
                         input int drop_b, input bit strays, input string name);
    int p, s, e, w, u, v, we_c, dv_c, err_c, rdy_from, last, stray_ecc, da, db, lim;
    logic [1:0] exp_stage;
    logic [7:0] got, exp;
    p = 1 + dp;
    s = -1; e = -1; w = -1; u = -1; v = -1;
    we_c = -1; dv_c = -1; err_c = -1; stray_ecc = -1;
    rdy_from = 1 << 30;
    exp_stage = 2'd0;
    if (dp > T - 1) begin
      err_c = 1 + T;
      exp_stage = 2'd0;
    end else if (m == 2'b00) begin
      dv_c = p + 1;
    end else if (m == 2'b11) begin
      we_c = p + 1;
      dv_c = p + 2;
    end else begin
      s = p + 1;
      e = s + de;
      if (de > T - 1) begin
        err_c = s + T;
        exp_stage = 2'd1;
      end else if (m == 2'b01) begin
        dv_c = e + 1;
      end else begin
        w = e + 1;
        rdy_from = (rdy_early && dw == 0) ? 0 : w + dw;
        if (dw > T - 1) begin
          err_c = w + T;
          exp_stage = 2'd2;
        end else begin
          u = w + dw + 1;
          v = u + dv;
          if (dv > T - 1) begin
            err_c = u + T;
            exp_stage = 2'd3;
          end else begin
            dv_c = v + 1;
          end
        end
      end
    end
    last = (err_c >= 0) ? err_c : dv_c;
    da = (drop_a <= 0) ? -1 : ((drop_a > last) ? last : drop_a);
    db = (drop_b <= 0) ? -1 : ((drop_b > last) ? last : drop_b);
    lim = (dp > T - 1) ? T : p - 1;
    if (strays && lim >= 1) stray_ecc = $urandom_range(1, lim);

    for (int k = 0; k <= last + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_before_req: busy got %b expected 0", name, busy);
        end
      end else begin
        exp = {k == 1, k == s, k == u, k == we_c, k == dv_c,
               (k - 1 == da) || (k - 1 == db), k <= last, (err_c >= 0) && (k >= err_c)};
        got = {puf_start, ecc_start, sha_init, mem_we, resp_dv, dropped, busy, err};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL %s cycle %0d {puf_start,ecc_start,sha_init,mem_we,resp_dv,dropped,busy,err} got %b expected %b",
                   name, k, got, exp);
        end
        checks++;
        if ({resp_sel, puf_challenge} !== {m, ch}) begin
          errors++;
          $display("FAIL %s cycle %0d latched {resp_sel,puf_challenge} got %h expected %h",
                   name, k, {resp_sel, puf_challenge}, {m, ch});
        end
        if (k == last + 1) begin
          checks++;
          if (err_stage !== exp_stage) begin
            errors++;
            $display("FAIL %s err_stage got %0d expected %0d", name, err_stage, exp_stage);
          end
        end
      end
      req              = (k == 0) || (k == da) || (k == db);
      mode             = (k == 0) ? m : 2'($urandom);
      challenge_in     = (k == 0) ? ch : 8'($urandom);
      puf_done         = (k == p) || (strays && (k == s || k == last + 1));
      ecc_ready        = (k == e) || (k == stray_ecc);
      sha_ready        = (k >= rdy_from);
      sha_digest_valid = (k == v) || (strays && k == u);
    end
  endtask

  task automatic test_reset();
    logic [20:0] got;
    repeat (2) @(negedge clk);
    got = {puf_start, ecc_start, sha_init, mem_we, resp_dv, dropped, busy, err,
           err_stage, resp_sel, puf_challenge};
    checks++;
    if (got !== 21'd0) begin
      errors++;
      $display("FAIL reset_values got %h expected 0", got);
    end
    // reset and req together: reset must win
    req = 1'b1; mode = 2'b10; challenge_in = 8'hFF;
    @(negedge clk);
    checks++;
    if ({busy, puf_start, resp_sel, puf_challenge} !== 12'd0) begin
      errors++;
      $display("FAIL reset_over_req got %h expected 0", {busy, puf_start, resp_sel, puf_challenge});
    end
    req = 1'b0; mode = 2'b00; challenge_in = 8'h00;
    reset = 1'b0;
  endtask

  task automatic test_raw();
    run_txn(2'b00, 8'h5A, 10, 0, 0, 0, 1'b0, 0, 0, 1'b0, "raw");
  endtask

  task automatic test_hashed();
    run_txn(2'b10, 8'hA7, 3, 2, 0, 5, 1'b1, 0, 0, 1'b0, "hashed");
    run_txn(2'b10, 8'h1E, 2, 4, 6, 3, 1'b0, 0, 0, 1'b0, "hashed_wait");
    run_txn(2'b01, 8'h77, 4, 3, 0, 0, 1'b0, 0, 0, 1'b0, "corrected");
  endtask

  task automatic test_enroll();
    run_txn(2'b11, 8'h03, 4, 0, 0, 0, 1'b0, 0, 0, 1'b0, "enroll");
  endtask

  task automatic test_timeout();
    run_txn(2'b01, 8'h11, 2, 40, 0, 1, 1'b0, 0, 0, 1'b0, "timeout_ecc");
    run_txn(2'b00, 8'h22, 1, 0, 0, 0, 1'b0, 0, 0, 1'b0, "after_timeout");
    run_txn(2'b00, 8'h33, 30, 0, 0, 0, 1'b0, 0, 0, 1'b0, "timeout_puf");
    run_txn(2'b10, 8'h44, 1, 1, 20, 1, 1'b0, 0, 0, 1'b0, "timeout_sha_wait");
    run_txn(2'b10, 8'h55, 1, 1, 0, 20, 1'b1, 0, 0, 1'b0, "timeout_sha_run");
    run_txn(2'b01, 8'h66, T - 1, T - 1, 0, 0, 1'b0, 0, 0, 1'b0, "done_at_expiry");
    run_txn(2'b10, 8'h67, 1, 1, T - 1, T - 1, 1'b0, 0, 0, 1'b0, "sha_at_expiry");
  endtask

  task automatic test_contention();
    run_txn(2'b00, 8'h3C, 6, 0, 0, 0, 1'b0, 3, 1000, 1'b1, "contention_raw");
    run_txn(2'b10, 8'hC5, 5, 3, 2, 4, 1'b0, 2, 1000, 1'b1, "contention_hash");
  endtask

  task automatic test_back_to_back();
    run_txn(2'b00, 8'h01, 1, 0, 0, 0, 1'b0, 0, 0, 1'b0, "b2b_0");
    run_txn(2'b11, 8'h02, 1, 0, 0, 0, 1'b0, 0, 0, 1'b0, "b2b_1");
    run_txn(2'b00, 8'h04, 1, 0, 0, 0, 1'b0, 0, 1000, 1'b0, "b2b_2");
  endtask

  task automatic test_reset_mid_sha();
    logic [20:0] got;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 6) begin
        checks++;
        if (sha_init !== 1'b1) begin
          errors++;
          $display("FAIL rst_mid_sha sha_init got %b expected 1", sha_init);
        end
      end
      if (k == 8) begin
        got = {puf_start, ecc_start, sha_init, mem_we, resp_dv, dropped, busy, err,
               err_stage, resp_sel, puf_challenge};
        checks++;
        if (got !== 21'd0) begin
          errors++;
          $display("FAIL rst_mid_sha outputs got %h expected 0", got);
        end
      end
      if (k > 8) begin
        checks++;
        if ({resp_dv, busy} !== 2'b00) begin
          errors++;
          $display("FAIL rst_mid_sha cycle %0d {resp_dv,busy} got %b expected 00", k, {resp_dv, busy});
        end
      end
      req              = (k == 0);
      mode             = 2'b10;
      challenge_in     = 8'hC3;
      puf_done         = (k == 2);
      ecc_ready        = (k == 4);
      sha_ready        = 1'b1;
      reset            = (k == 7);
      sha_digest_valid = (k >= 8 && k <= 10);
    end
    req = 1'b0; sha_ready = 1'b0; sha_digest_valid = 1'b0; reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_txn(2'($urandom_range(0, 3)), 8'($urandom),
              int'($urandom_range(1, T + 2)), int'($urandom_range(1, T + 2)),
              int'($urandom_range(0, T + 2)), int'($urandom_range(1, T + 2)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0,
              ($urandom_range(0, 3) == 0) ? 1000 : 0,
              1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; mode = 2'b00; challenge_in = 8'h00;
    puf_done = 1'b0; ecc_ready = 1'b0; sha_ready = 1'b0; sha_digest_valid = 1'b0;
    test_reset();
    test_raw();
    test_hashed();
    test_enroll();
    test_timeout();
    test_contention();
    test_back_to_back();
    test_reset_mid_sha();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
